// File: rtl/uart_rx_pusher.sv
// uart_rx_pusher: 8N1 UART receiver that pushes each good byte into a downstream byte FIFO
// through an active-low push strobe, dropping (and flagging) bytes that arrive while it is full.
// Optional macro UART_RX_PARITY_EN switches the frame format to 8E1.
module uart_rx_pusher #(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned PUSH_LEN   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       full,
   output logic [7:0] data,
   output logic       push_n,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned DIV = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned SW  = $clog2(OVERSAMPLE);
   localparam int unsigned PW  = $clog2(PUSH_LEN);

   localparam logic [DW-1:0] DivMax   = DW'(DIV - 1);
   localparam logic [SW-1:0] SampHalf = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SampMax  = SW'(OVERSAMPLE - 1);
   localparam logic [PW-1:0] PushMax  = PW'(PUSH_LEN - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop,
      StBreak,
      StPush
   } state_e;

   state_e          state_q, state_d;
   logic            rx_meta_q, rxs_q, rxs_prev_q;
   logic [DW-1:0]   div_q;
   logic [SW-1:0]   samp_q;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic [PW-1:0]   push_cnt_q, push_cnt_d;
   logic            push_n_q, push_n_d;
   logic            busy_q, busy_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;
   logic            pend_q, pend_d;
`ifdef UART_RX_PARITY_EN
   logic            par_err_q, par_err_d;
`endif

   logic fall;
   logic tick;
   logic start_clr;
   logic samp_mid;

   assign fall      = rxs_prev_q & ~rxs_q;
   assign tick      = (div_q == DivMax);
   // Start edges seen while pushing are kept so the next frame is not lost
   assign start_clr = fall && ((state_q == StIdle) || (state_q == StPush));
   assign samp_mid  = tick && (samp_q == SampMax);

   // Two-flop synchroniser plus previous-value flop for edge detection; idle line is high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q  <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         rx_meta_q  <= rx;
         rxs_q      <= rx_meta_q;
         rxs_prev_q <= rxs_q;
      end
   end

   // Oversample tick divider, re-phased to the start edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q <= '0;
      end else if (start_clr || tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DW'(1);
      end
   end

   // Sample counter: half a bit to mid-start, then whole bits between mid-bit samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         samp_q <= '0;
      end else if (start_clr) begin
         samp_q <= '0;
      end else if (tick) begin
         if (((state_q == StStart) && (samp_q == SampHalf)) || (samp_q == SampMax)) begin
            samp_q <= '0;
         end else begin
            samp_q <= samp_q + SW'(1);
         end
      end
   end

   // FSM and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         bit_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         push_cnt_q  <= '0;
         push_n_q    <= 1'b1;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         pend_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         push_cnt_q  <= push_cnt_d;
         push_n_q    <= push_n_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         pend_q      <= pend_d;
`ifdef UART_RX_PARITY_EN
         par_err_q   <= par_err_d;
`endif
      end
   end

   // Next-state and register update decisions
   always_comb begin
      state_d     = state_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      data_d      = data_q;
      push_cnt_d  = push_cnt_q;
      push_n_d    = push_n_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
      pend_d      = pend_q;
`ifdef UART_RX_PARITY_EN
      par_err_d   = par_err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (fall) state_d = StStart;
         end
         StStart: begin
            if (tick && (samp_q == SampHalf)) begin
               if (!rxs_q) begin
                  state_d = StData;
                  bit_d   = '0;
               end else begin
                  state_d = StIdle;  // glitch, not a start bit
               end
            end
         end
         StData: begin
            if (samp_mid) begin
               shift_d = {rxs_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (bit_q == 3'd7) state_d = StParity;
`else
               if (bit_q == 3'd7) state_d = StStop;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (samp_mid) begin
               par_err_d = rxs_q ^ (^shift_q);
               state_d   = StStop;
            end
         end
`endif
         StStop: begin
            if (samp_mid) begin
               if (rxs_q) begin
                  frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                  if (par_err_q) begin
                     frame_err_d = 1'b1;
                     state_d     = StIdle;
                  end else
`endif
                  if (full) begin
                     overrun_d = 1'b1;
                     state_d   = StIdle;
                  end else begin
                     data_d     = shift_q;
                     push_n_d   = 1'b0;
                     push_cnt_d = '0;
                     pend_d     = 1'b0;
                     state_d    = StPush;
                  end
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StBreak;
               end
            end
         end
         StBreak: begin
            if (rxs_q) state_d = StIdle;
         end
         StPush: begin
            push_cnt_d = push_cnt_q + PW'(1);
            if (fall) pend_d = 1'b1;
            if (push_cnt_q == PushMax) begin
               push_n_d = 1'b1;
               pend_d   = 1'b0;
               state_d  = (pend_q || fall) ? StStart : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   assign data      = data_q;
   assign push_n    = push_n_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_pusher.sv
// Scoreboard bench for uart_rx_pusher: stimulus pushes expected bytes, a monitor checks pushes.
module tb_uart_rx_pusher;

   localparam int BIT = 160;  // clk per bit at 1.6 MHz / 10 kBd

   logic       clk;
   logic       reset;
   logic       rx;
   logic       full;
   logic [7:0] data;
   logic       push_n;
   logic       busy;
   logic       frame_err;
   logic       overrun;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
   logic par_flip = 1'b0;
`endif

   uart_rx_pusher #(
      .CLK_HZ    (1600000),
      .BAUD      (10000),
      .OVERSAMPLE(16),
      .PUSH_LEN  (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .full     (full),
      .data     (data),
      .push_n   (push_n),
      .busy     (busy),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      wait_clks(BIT);
      check("busy_in_frame", int'(busy), 1);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clks(BIT);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^b) ^ par_flip;
      wait_clks(BIT);
`endif
      rx = stop_bit;
      wait_clks(BIT);
   endtask

   // Monitor: every push_n falling edge pops one expected byte; pulse width is checked on release
   initial begin
      logic prev_push_n;
      int   low_cnt;
      prev_push_n = 1'b1;
      low_cnt     = 0;
      forever begin
         @(negedge clk);
         if (prev_push_n && !push_n) begin
            if (exp_q.size() == 0) begin
               check("unexpected_push", int'(data), -1);
            end else begin
               check("push_data", int'(data), int'(exp_q.pop_front()));
               check("push_frame_err", int'(frame_err), 0);
            end
         end
         if (!push_n) low_cnt++;
         if (!prev_push_n && push_n) begin
            check("push_width", low_cnt, 2);
            low_cnt = 0;
         end
         prev_push_n = push_n;
      end
   end

   initial begin
      #(100000 * 10);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rx    = 1'b1;
      full  = 1'b0;
      reset = 1'b1;
      wait_clks(5);
      check("rst_data", int'(data), 8'h00);
      check("rst_push_n", int'(push_n), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_err", int'(frame_err), 0);
      check("rst_overrun", int'(overrun), 0);
      reset = 1'b0;
      wait_clks(20);

      // Single good byte
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, 1'b1);
      wait_clks(20);
      check("a5_pending", exp_q.size(), 0);
      check("a5_data", int'(data), 8'hA5);
      check("a5_busy", int'(busy), 0);
      check("a5_frame_err", int'(frame_err), 0);
      check("a5_overrun", int'(overrun), 0);

      // Back-to-back frames
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hC3);
      send_byte(8'h3C, 1'b1);
      check("b2b_first_data", int'(data), 8'h3C);
      send_byte(8'hC3, 1'b1);
      wait_clks(20);
      check("b2b_pending", exp_q.size(), 0);
      check("b2b_data", int'(data), 8'hC3);

      // Short low glitch is rejected
      rx = 1'b0;
      wait_clks(40);
      rx = 1'b1;
      wait_clks(2000);
      check("glitch_busy", int'(busy), 0);
      check("glitch_data", int'(data), 8'hC3);
      check("glitch_frame_err", int'(frame_err), 0);
      check("glitch_overrun", int'(overrun), 0);

      // Bad stop bit then line held low
      send_byte(8'h55, 1'b0);
      wait_clks(2000);
      check("brk_frame_err", int'(frame_err), 1);
      check("brk_data", int'(data), 8'hC3);
      check("brk_busy", int'(busy), 1);
      rx = 1'b1;
      wait_clks(320);
      check("brk_release_busy", int'(busy), 0);
      exp_q.push_back(8'h01);
      send_byte(8'h01, 1'b1);
      wait_clks(20);
      check("brk_recover_pending", exp_q.size(), 0);
      check("brk_recover_data", int'(data), 8'h01);
      check("brk_recover_frame_err", int'(frame_err), 0);

      // Full FIFO: byte dropped and overrun flagged
      full = 1'b1;
      send_byte(8'h7E, 1'b1);
      wait_clks(20);
      full = 1'b0;
      check("full_data", int'(data), 8'h01);
      check("full_overrun", int'(overrun), 1);
      exp_q.push_back(8'h11);
      send_byte(8'h11, 1'b1);
      wait_clks(20);
      check("after_full_pending", exp_q.size(), 0);
      check("after_full_data", int'(data), 8'h11);
      check("after_full_overrun", int'(overrun), 1);

      // Reset in the middle of bit 4 of 0xFF
      rx = 1'b0;
      wait_clks(BIT);
      rx = 1'b1;
      wait_clks(4 * BIT + BIT / 2);
      check("pre_rst_busy", int'(busy), 1);
      reset = 1'b1;
      #1;
      check("mid_rst_data", int'(data), 8'h00);
      check("mid_rst_push_n", int'(push_n), 1);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_frame_err", int'(frame_err), 0);
      check("mid_rst_overrun", int'(overrun), 0);
      wait_clks(3);
      reset = 1'b0;
      wait_clks(4 * BIT);
      exp_q.push_back(8'h80);
      send_byte(8'h80, 1'b1);
      wait_clks(20);
      check("post_rst_pending", exp_q.size(), 0);
      check("post_rst_data", int'(data), 8'h80);

`ifdef UART_RX_PARITY_EN
      // Wrong parity: discarded, flagged, no overrun
      par_flip = 1'b1;
      send_byte(8'h07, 1'b1);
      par_flip = 1'b0;
      wait_clks(20);
      check("par_frame_err", int'(frame_err), 1);
      check("par_data", int'(data), 8'h80);
      check("par_overrun", int'(overrun), 0);
      exp_q.push_back(8'h07);
      send_byte(8'h07, 1'b1);
      wait_clks(20);
      check("par_good_pending", exp_q.size(), 0);
      check("par_good_frame_err", int'(frame_err), 0);
`endif

      wait_clks(50);
      check("final_pending", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_pusher.md
Name: uart_rx_pusher

Overview:
Serial byte receiver that sits directly upstream of the 16-deep byte FIFO.
- Deserialises 8N1 UART frames from an external rx pin.
- Presents each received byte on data.
- Drives the FIFO's active-low push input with a clean low pulse, which the FIFO's falling-edge detector converts to a single write.
- Observes the FIFO full flag, so bytes arriving while full are dropped and flagged instead of lost silently.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz.
BAUD, 9600, serial bit rate.
OVERSAMPLE, 16, sample ticks per bit; must be even and >= 4.
PUSH_LEN, 2, clk cycles push_n is held low per accepted byte; >= 2.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
rx  in  1  asynchronous serial input, idle high.
full  in  1  FIFO full flag, synchronous to clk.
data  out  8  last received byte; stable from push_n falling edge until the next accepted frame.
push_n  out  1  active-low push strobe to the FIFO.
busy  out  1  high from start-bit detect until return to IDLE.
frame_err  out  1  sticky; set on a bad stop bit (or bad parity, see option); cleared by the next good frame.
overrun  out  1  sticky; set when a good frame arrives while full=1; cleared only by reset.

Behaviour:
- Reset values: data=0, push_n=1, busy=0, frame_err=0, overrun=0, FSM=IDLE. Synchroniser flops reset to 1.
- rx passes through a 2-FF synchroniser; all logic uses the synchronised rxs.
- Tick generator: divider DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer truncation, DIV >= 2.
  - Tick is 1 clk wide every DIV clks.
  - Counter is cleared on start detect, so sampling phase is aligned to the start edge.
- Sample counter: width clog2(OVERSAMPLE), wraps at OVERSAMPLE-1. Bit counter: 3 bits.
- FSM states:
  - IDLE: busy=0. rxs falling (prev 1, now 0) -> START, busy=1.
  - START: after OVERSAMPLE/2 ticks, sample rxs.
    - 0 -> DATA, sample counter cleared.
    - 1 -> false start, back to IDLE, no flags changed.
  - DATA: every OVERSAMPLE ticks (mid-bit), shift rxs into the shift register LSB-first. After bit 7 -> STOP.
  - STOP: after OVERSAMPLE ticks, sample rxs.
    - 1 and full=0: data<=shift register, frame_err<=0, go to PUSH.
    - 1 and full=1: data unchanged, overrun<=1, frame_err<=0, go to IDLE (no push).
    - 0: frame_err<=1, data unchanged, go to BREAK.
  - BREAK: wait until rxs=1, then IDLE. A line held low never produces spurious frames.
  - PUSH: push_n=0 for exactly PUSH_LEN clks, then push_n=1, then IDLE.
    - push_n returns high at least one full bit time before the next possible push.
- full is sampled only in the STOP decision cycle; changes of full during PUSH do not abort the pulse.
- A start edge during PUSH is not lost: PUSH (<= PUSH_LEN clks) completes long before mid-start-bit. The falling edge is latched and START is entered straight from PUSH.
- Reset asserted mid-frame: immediate return to reset values; the partial byte is discarded.
- Total latency: push_n falls 1 clk after the mid-stop-bit sample tick.

Optional Feature:
UART_RX_PARITY_EN
- Defined: frame is 8E1. State PARITY is inserted between DATA and STOP and samples one bit mid-bit.
  - Mismatch with even parity of the 8 data bits sets frame_err.
  - The frame is discarded (no push, no overrun), FSM still proceeds through STOP.
- Undefined: 8N1 as above; no PARITY state or logic present.

Test Plan:
All scenarios use CLK_HZ=1600000, BAUD=10000, OVERSAMPLE=16 (DIV=10, 160 clk/bit).
- Reset then send 0xA5 8N1, full=0 -> one push_n low pulse of 2 clks, data=0xA5, frame_err=0, overrun=0, busy drops after pulse.
- Send 0x3C then 0xC3 back-to-back, no idle gap -> two distinct push_n pulses, data=0x3C then 0xC3, each stable from its pulse until the next.
- 3-clk-wide... rx glitch low for 40 clk (less than half a bit) -> return to IDLE, no push_n pulse, flags unchanged.
- Send 0x55 with stop bit forced 0, line held low for 2000 clk then released, then send 0x01 -> frame_err=1 and no push for the first; no activity while low; 0x01 pushed and frame_err cleared to 0.
- Hold full=1 and send 0x7E -> no push_n pulse, data keeps its old value, overrun=1. Release full and send 0x11 -> pushed, overrun stays 1.
- Assert reset at bit 4 of 0xFF -> all outputs at reset values. Then send 0x80 -> data=0x80 pushed correctly. With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> frame_err=1, no push.
